cam_capture_scaler: RTL and testbench

Parametrised capture front end for the OV7670 pixel bus, running in the camera pclk domain. It assembles two-byte pixels in either YUV422 (grey from Y) or RGB565 format and decimates them 1:1, 1:2 or 1:4 in both axes. The resulting 12-bit RGB444 pixels are written to the capture frame memory through an addr/dout/we port. It also provides frame-boundary mode latching, a freeze (pause) control, a frame counter and a geometry-error flag.

---
 rtl/cam_capture_scaler.sv | 165 ++++++++++++++++
 tb/tb_cam_capture_scaler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_scaler.sv
// OV7670 capture front end: assembles YUV422/RGB565 pixels, decimates 1:1/1:2/1:4 and writes RGB444 words.
// Optional CAP_FRAME_STATS_EN adds a per-frame pixel sum output (frame_sum).
module cam_capture_scaler #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19,
    parameter int FCNT_W = 8
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    input  logic              fmt,
    input  logic [1:0]        scale,
    input  logic              freeze,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              geom_err
`ifdef CAP_FRAME_STATS_EN
    ,
    output logic [31:0]       frame_sum
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT);

    typedef enum logic [1:0] {WAIT_VS, BLANK, ACTIVE} state_t;

    state_t            state;
    logic              vs_r, hr_r, hr_d;
    logic [7:0]        din_r;
    logic              fmt_s, frz_s;
    logic [1:0]        scale_s;
    logic              phase;
    logic              line_pix;
    logic [3:0]        b0_hi;
    logic [2:0]        b0_lo;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] wr_ptr;
`ifdef CAP_FRAME_STATS_EN
    logic [31:0]       acc;
`endif

    logic        hr_fall, pix_done, in_range, keep;
    logic [1:0]  step_mask;
    logic [11:0] pix;

    // Decimation keeps a pixel only when the low coordinate bits under the step mask are zero
    always_comb begin
        hr_fall   = hr_d & ~hr_r;
        pix_done  = hr_r & phase;
        step_mask = (scale_s == 2'd0) ? 2'b00 : (scale_s == 2'd1) ? 2'b01 : 2'b11;
        in_range  = (col < COL_MAX) && (row < ROW_MAX);
        keep      = ((col[1:0] & step_mask) == 2'b00) && ((row[1:0] & step_mask) == 2'b00);
        pix       = fmt_s ? {b0_hi, b0_lo, din_r[7], din_r[4:1]} : {b0_hi, b0_hi, b0_hi};
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= WAIT_VS;
            vs_r       <= 1'b0;
            hr_r       <= 1'b0;
            hr_d       <= 1'b0;
            din_r      <= '0;
            fmt_s      <= 1'b0;
            frz_s      <= 1'b0;
            scale_s    <= '0;
            phase      <= 1'b0;
            line_pix   <= 1'b0;
            b0_hi      <= '0;
            b0_lo      <= '0;
            col        <= '0;
            row        <= '0;
            wr_ptr     <= '0;
            addr       <= '0;
            dout       <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            geom_err   <= 1'b0;
`ifdef CAP_FRAME_STATS_EN
            acc        <= '0;
            frame_sum  <= '0;
`endif
        end else begin
            vs_r       <= vsync;
            hr_r       <= href;
            din_r      <= din;
            hr_d       <= hr_r;
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                WAIT_VS: begin
                    if (vs_r) state <= BLANK;
                end
                BLANK: begin
                    // Frame controls are sampled only here so mid-frame changes wait for the next frame
                    if (!vs_r) begin
                        fmt_s    <= fmt;
                        scale_s  <= scale;
                        frz_s    <= freeze;
                        col      <= '0;
                        row      <= '0;
                        wr_ptr   <= '0;
                        addr     <= '0;
                        phase    <= 1'b0;
                        line_pix <= 1'b0;
`ifdef CAP_FRAME_STATS_EN
                        acc      <= '0;
`endif
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (vs_r) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + FCNT_W'(1);
                        phase      <= 1'b0;
`ifdef CAP_FRAME_STATS_EN
                        frame_sum  <= acc;
`endif
                        state      <= BLANK;
                    end else begin
                        phase <= hr_r ? ~phase : 1'b0;
                        if (hr_r && !phase) begin
                            b0_hi <= din_r[7:4];
                            b0_lo <= din_r[2:0];
                        end
                        if (hr_fall) begin
                            col      <= '0;
                            line_pix <= 1'b0;
                            if (line_pix && row < ROW_MAX) row <= row + RW'(1);
                        end
                        // Counters saturate at the limit; anything past it only raises geom_err
                        if (pix_done) begin
                            line_pix <= 1'b1;
                            if (col < COL_MAX) col <= col + CW'(1);
                            if (!in_range) begin
                                geom_err <= 1'b1;
                            end else if (keep && !frz_s) begin
                                we     <= 1'b1;
                                dout   <= pix;
                                addr   <= wr_ptr;
                                wr_ptr <= wr_ptr + ADDR_W'(1);
`ifdef CAP_FRAME_STATS_EN
                                acc    <= acc + {20'd0, pix};
`endif
                            end
                        end
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_scaler.sv
// Scoreboard bench for cam_capture_scaler with an 8x4 frame; checks frame_sum when CAP_FRAME_STATS_EN is defined.
module tb_cam_capture_scaler;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 6;
    localparam int FW = 8;

    logic          pclk;
    logic          rst;
    logic          vsync;
    logic          href;
    logic [7:0]    din;
    logic          fmt;
    logic [1:0]    scale;
    logic          freeze;
    logic [AW-1:0] addr;
    logic [11:0]   dout;
    logic          we;
    logic          frame_done;
    logic [FW-1:0] frame_cnt;
    logic          geom_err;
`ifdef CAP_FRAME_STATS_EN
    logic [31:0]   frame_sum;
`endif

    cam_capture_scaler #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .FCNT_W(FW)) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .din        (din),
        .fmt        (fmt),
        .scale      (scale),
        .freeze     (freeze),
        .addr       (addr),
        .dout       (dout),
        .we         (we),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .geom_err   (geom_err)
`ifdef CAP_FRAME_STATS_EN
        ,
        .frame_sum  (frame_sum)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [11:0]   d;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          exp_fcnt = 0;
    logic        exp_geom = 1'b0;
    logic [31:0] exp_sum = '0;
    int          line_bytes[4];

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    function automatic logic [11:0] model_pix(input logic f, input logic [7:0] b0, input logic [7:0] b1);
        if (f) return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
        return {b0[7:4], b0[7:4], b0[7:4]};
    endfunction

    // Every write the DUT makes must match the head of the expected queue
    always @(negedge pclk) begin
        if (frame_done) done_cnt++;
        if (we) begin
            if (exp_q.size() == 0) begin
                checkOutput("we_unexpected", {31'd0, we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("addr", 32'(addr), 32'(mon_e.a));
                checkOutput("dout", 32'(dout), 32'(mon_e.d));
            end
        end
    end

    task automatic drive_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
        for (int b = 0; b < nbytes; b++) begin
            href = 1'b1;
            din  = (b % 2 == 0) ? b0 : b1;
            tick(1);
        end
        href = 1'b0;
        din  = 8'h00;
        tick(4);
    endtask

    task automatic applyStimulus(input logic f, input logic [1:0] sc, input logic frz,
                                 input logic [7:0] b0, input logic [7:0] b1,
                                 input logic mid_en, input logic [1:0] mid_sc);
        int step;
        int a;
        int r;
        int npix;
        logic [11:0] p;
        step    = (sc == 2'd0) ? 1 : (sc == 2'd1) ? 2 : 4;
        a       = 0;
        r       = 0;
        exp_sum = '0;
        p       = model_pix(f, b0, b1);
        for (int l = 0; l < 4; l++) begin
            npix = line_bytes[l] / 2;
            for (int c = 0; c < npix; c++) begin
                if (c >= W || r >= H) begin
                    exp_geom = 1'b1;
                end else if (c % step == 0 && r % step == 0 && !frz) begin
                    exp_q.push_back('{a: AW'(a), d: p});
                    exp_sum += 32'(p);
                    a++;
                end
            end
            if (npix > 0) r++;
        end

        vsync  = 1'b1;
        href   = 1'b0;
        fmt    = f;
        scale  = sc;
        freeze = frz;
        tick(4);
        vsync = 1'b0;
        tick(3);
        for (int l = 0; l < 4; l++) begin
            drive_line(line_bytes[l], b0, b1);
            if (l == 0 && mid_en) scale = mid_sc;
        end
        vsync = 1'b1;
        tick(6);
        exp_done++;
        exp_fcnt++;
        checkOutput("writes_pending", 32'(exp_q.size()), 32'd0);
        checkOutput("frame_done_count", 32'(done_cnt), 32'(exp_done));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        checkOutput("geom_err", {31'd0, geom_err}, {31'd0, exp_geom});
`ifdef CAP_FRAME_STATS_EN
        checkOutput("frame_sum", frame_sum, exp_sum);
`endif
    endtask

    initial begin
        rst    = 1'b1;
        vsync  = 1'b0;
        href   = 1'b0;
        din    = 8'h00;
        fmt    = 1'b0;
        scale  = 2'd0;
        freeze = 1'b0;
        tick(3);
        checkOutput("rst_we", {31'd0, we}, 32'd0);
        checkOutput("rst_addr", 32'(addr), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_geom_err", {31'd0, geom_err}, 32'd0);
        rst = 1'b0;
        tick(2);

        line_bytes = '{16, 16, 16, 16};
        applyStimulus(1'b1, 2'd0, 1'b0, 8'hFF, 8'hFF, 1'b0, 2'd0);
        applyStimulus(1'b0, 2'd1, 1'b0, 8'hA5, 8'h00, 1'b0, 2'd0);
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h3C, 8'h96, 1'b1, 2'd0);
        applyStimulus(1'b1, 2'd0, 1'b0, 8'h3C, 8'h96, 1'b0, 2'd0);
        applyStimulus(1'b1, 2'd0, 1'b1, 8'hFF, 8'hFF, 1'b0, 2'd0);
        applyStimulus(1'b1, 2'd0, 1'b0, 8'h00, 8'h1F, 1'b0, 2'd0);
        applyStimulus(1'b0, 2'd3, 1'b0, 8'h5A, 8'h00, 1'b0, 2'd0);

        line_bytes = '{18, 16, 16, 16};
        applyStimulus(1'b1, 2'd0, 1'b0, 8'hC3, 8'h7E, 1'b0, 2'd0);
        line_bytes = '{16, 16, 16, 16};
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h81, 8'h00, 1'b0, 2'd0);

        // Reset after ten written pixels: those writes appear, the frame never completes
        vsync  = 1'b1;
        fmt    = 1'b1;
        scale  = 2'd0;
        freeze = 1'b0;
        tick(4);
        vsync = 1'b0;
        tick(3);
        for (int i = 0; i < 10; i++) exp_q.push_back('{a: AW'(i), d: 12'hFFF});
        drive_line(16, 8'hFF, 8'hFF);
        drive_line(4, 8'hFF, 8'hFF);
        rst = 1'b1;
        tick(1);
        checkOutput("midrst_we", {31'd0, we}, 32'd0);
        checkOutput("midrst_addr", 32'(addr), 32'd0);
        checkOutput("midrst_dout", 32'(dout), 32'd0);
        checkOutput("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        checkOutput("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("midrst_geom_err", {31'd0, geom_err}, 32'd0);
        checkOutput("midrst_writes_pending", 32'(exp_q.size()), 32'd0);
        tick(1);
        rst      = 1'b0;
        exp_fcnt = 0;
        exp_geom = 1'b0;
        drive_line(16, 8'hFF, 8'hFF);
        drive_line(16, 8'hFF, 8'hFF);
        checkOutput("no_done_after_rst", 32'(done_cnt), 32'(exp_done));
        applyStimulus(1'b1, 2'd0, 1'b0, 8'hFF, 8'hFF, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
